// File: rtl/testcore_sysid_pkg.sv
// Shared types and default constants for the system-ID boot checker and arbiter.
package testcore_sysid_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [2:0] {
      SETTLE = 3'd0,
      CHK_ID = 3'd1,
      CHK_TS = 3'd2,
      RUN    = 3'd3,
      FAULT  = 3'd4
   } state_e;

   localparam logic [DATA_W-1:0] DEFAULT_EXPECTED_ID        = 32'h2014_1113;
   localparam logic [DATA_W-1:0] DEFAULT_EXPECTED_TIMESTAMP = 32'h5464_D6F2;
   localparam logic [DATA_W-1:0] DEFAULT_ERROR_WORD         = 32'hDEAD_BEEF;

   // Word returned to a master: the slave word, or the error word once faulted.
   function automatic logic [DATA_W-1:0] resp_word(input logic             fault,
                                                   input logic [DATA_W-1:0] slave_word,
                                                   input logic [DATA_W-1:0] err_word);
      return fault ? err_word : slave_word;
   endfunction

endpackage

// File: rtl/testcore_sysid_arbiter_if.sv
// Avalon-MM read-only port: one master's view of the shared system-ID slave.
interface testcore_sysid_arbiter_if;
   import testcore_sysid_pkg::*;

   logic              address;
   logic              read;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/testcore_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module testcore_rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant_c
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant_c      = 2'b00;
      last_grant_d = last_grant_q;
      if (en) begin
         case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
         endcase
      end
      if (grant_c[1]) begin
         last_grant_d = 1'b1;
      end else if (grant_c[0]) begin
         last_grant_d = 1'b0;
      end
   end

   // Reset to 1 so master 0 wins the first tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/testcore_sysid_arbiter.sv
// Boot-time system-ID check followed by round-robin sharing of the sysid slave
// between two Avalon-MM read masters with a one-cycle registered response.
module testcore_sysid_arbiter
   import testcore_sysid_pkg::*;
#(
   parameter logic [DATA_W-1:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
   parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
   parameter bit                CHECK_TIMESTAMP    = 1'b1,
   parameter int unsigned       SETTLE_CYCLES      = 4,
   parameter bit                STRICT             = 1'b0,
   parameter logic [DATA_W-1:0] ERROR_WORD         = DEFAULT_ERROR_WORD
) (
   input  logic                     clock,
   input  logic                     reset,
   testcore_sysid_arbiter_if.slave  m0,
   testcore_sysid_arbiter_if.slave  m1,
   output logic                     s_address,
   input  logic [DATA_W-1:0]        s_readdata,
   output logic                     check_done,
   output logic                     check_pass
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              id_ok_q, id_ok_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              s_addr_q, s_addr_c;
   logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic              rv0_q, rv0_d, rv1_q, rv1_d;

   logic              arb_en_c;
   logic [1:0]        grant_c;
   logic              pass_c;
   logic [DATA_W-1:0] resp_c;

   assign arb_en_c = (state_q == RUN) || (state_q == FAULT);

   testcore_rr_arb2 u_arb (
      .clock   (clock),
      .reset   (reset),
      .en      (arb_en_c),
      .req     ({m1.read, m0.read}),
      .grant_c (grant_c)
   );

   // Boot sequence, check result and slave address selection.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      id_ok_d  = id_ok_q;
      done_d   = done_q;
      pass_d   = pass_q;
      s_addr_c = s_addr_q;
      pass_c   = 1'b0;
      case (state_q)
         SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_d = CHK_ID;
            end
         end
         CHK_ID: begin
            s_addr_c = 1'b0;
            id_ok_d  = (s_readdata == EXPECTED_ID);
            state_d  = CHK_TS;
         end
         CHK_TS: begin
            s_addr_c = 1'b1;
            pass_c   = id_ok_q & (!CHECK_TIMESTAMP || (s_readdata == EXPECTED_TIMESTAMP));
            done_d   = 1'b1;
            pass_d   = pass_c;
            state_d  = (STRICT && !pass_c) ? FAULT : RUN;
         end
         RUN, FAULT: begin
            if (grant_c[0]) begin
               s_addr_c = m0.address;
            end else if (grant_c[1]) begin
               s_addr_c = m1.address;
            end
         end
         default: state_d = SETTLE;
      endcase
   end

   // Response capture: only the granted master's data register updates.
   always_comb begin
      resp_c = resp_word(state_q == FAULT, s_readdata, ERROR_WORD);
      rd0_d  = grant_c[0] ? resp_c : rd0_q;
      rd1_d  = grant_c[1] ? resp_c : rd1_q;
      rv0_d  = grant_c[0];
      rv1_d  = grant_c[1];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= SETTLE;
         cnt_q    <= '0;
         id_ok_q  <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         s_addr_q <= 1'b0;
         rd0_q    <= '0;
         rd1_q    <= '0;
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         id_ok_q  <= id_ok_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         s_addr_q <= s_addr_c;
         rd0_q    <= rd0_d;
         rd1_q    <= rd1_d;
         rv0_q    <= rv0_d;
         rv1_q    <= rv1_d;
      end
   end

   assign s_address        = s_addr_c;
   assign check_done       = done_q;
   assign check_pass       = pass_q;
   assign m0.waitrequest   = ~grant_c[0];
   assign m1.waitrequest   = ~grant_c[1];
   assign m0.readdata      = rd0_q;
   assign m1.readdata      = rd1_q;
   assign m0.readdatavalid = rv0_q;
   assign m1.readdatavalid = rv1_q;

endmodule

// File: tb/tb_testcore_sysid_arbiter.sv
// Bench: strict/timestamp-checking DUT driven by directed and random reads,
// plus a non-strict DUT with timestamp checking disabled.
module tb_testcore_sysid_arbiter;
   import testcore_sysid_pkg::*;

   localparam logic [31:0] EXP_ID  = 32'h2014_1113;
   localparam logic [31:0] EXP_TS  = 32'h5464_D6F2;
   localparam logic [31:0] ERR_W   = 32'hDEAD_BEEF;

   logic        clock;
   logic        reset;
   logic        s_addr_a, s_addr_b;
   logic [31:0] s_rd_a, s_rd_b;
   logic        done_a, pass_a, done_b, pass_b;
   logic [31:0] id_a, ts_a, id_b, ts_b;

   int checks;
   int failures;

   int          last_g;
   bit          fault_m;
   logic [31:0] rd0_m, rd1_m;
   logic        saddr_m;

   testcore_sysid_arbiter_if if_a0 ();
   testcore_sysid_arbiter_if if_a1 ();
   testcore_sysid_arbiter_if if_b0 ();
   testcore_sysid_arbiter_if if_b1 ();

   // Behavioural sysid slaves: combinational read of ID / timestamp.
   assign s_rd_a = s_addr_a ? ts_a : id_a;
   assign s_rd_b = s_addr_b ? ts_b : id_b;

   testcore_sysid_arbiter #(
      .CHECK_TIMESTAMP (1'b1),
      .SETTLE_CYCLES   (4),
      .STRICT          (1'b1)
   ) dut_a (
      .clock      (clock),
      .reset      (reset),
      .m0         (if_a0.slave),
      .m1         (if_a1.slave),
      .s_address  (s_addr_a),
      .s_readdata (s_rd_a),
      .check_done (done_a),
      .check_pass (pass_a)
   );

   testcore_sysid_arbiter #(
      .CHECK_TIMESTAMP (1'b0),
      .SETTLE_CYCLES   (4),
      .STRICT          (1'b0)
   ) dut_b (
      .clock      (clock),
      .reset      (reset),
      .m0         (if_b0.slave),
      .m1         (if_b1.slave),
      .s_address  (s_addr_b),
      .s_readdata (s_rd_b),
      .check_done (done_b),
      .check_pass (pass_b)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle on dut_a: drive requests, check stall/address, then the response.
   task automatic step(input bit r0, input bit a0, input bit r1, input bit a1);
      int          g;
      logic [31:0] d;
      if_a0.read    = r0;
      if_a0.address = a0;
      if_a1.read    = r1;
      if_a1.address = a1;
      g = -1;
      if (r0 && r1)  g = (last_g == 0) ? 1 : 0;
      else if (r0)   g = 0;
      else if (r1)   g = 1;
      #1;
      chk("m0_waitrequest", 32'(if_a0.waitrequest), 32'(g != 0));
      chk("m1_waitrequest", 32'(if_a1.waitrequest), 32'(g != 1));
      if (g == 0) saddr_m = a0;
      if (g == 1) saddr_m = a1;
      chk("s_address", 32'(s_addr_a), 32'(saddr_m));
      d = '0;
      if (g >= 0) begin
         d      = fault_m ? ERR_W : (saddr_m ? ts_a : id_a);
         last_g = g;
      end
      if (g == 0) rd0_m = d;
      if (g == 1) rd1_m = d;
      @(posedge clock);
      @(negedge clock);
      chk("m0_readdatavalid", 32'(if_a0.readdatavalid), 32'(g == 0));
      chk("m1_readdatavalid", 32'(if_a1.readdatavalid), 32'(g == 1));
      chk("m0_readdata", if_a0.readdata, rd0_m);
      chk("m1_readdata", if_a1.readdata, rd1_m);
   endtask

   // Reset, reset-value checks, then cycle-accurate boot check timing.
   task automatic boot(input bit exp_pass_a, input bit exp_pass_b);
      reset = 1'b1;
      if_a0.read = 1'b1;
      if_a1.read = 1'b1;
      @(negedge clock);
      chk("rst_m0_waitrequest", 32'(if_a0.waitrequest), 32'd1);
      chk("rst_m1_waitrequest", 32'(if_a1.waitrequest), 32'd1);
      chk("rst_m0_readdatavalid", 32'(if_a0.readdatavalid), 32'd0);
      chk("rst_m1_readdatavalid", 32'(if_a1.readdatavalid), 32'd0);
      chk("rst_m0_readdata", if_a0.readdata, 32'd0);
      chk("rst_m1_readdata", if_a1.readdata, 32'd0);
      chk("rst_check_done", 32'(done_a), 32'd0);
      chk("rst_check_pass", 32'(pass_a), 32'd0);
      chk("rst_s_address", 32'(s_addr_a), 32'd0);
      last_g  = 1;
      fault_m = 1'b0;
      rd0_m   = '0;
      rd1_m   = '0;
      reset   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if_a0.read    = 1'b1;
         if_a1.read    = 1'b1;
         if_a0.address = 1'($urandom_range(0, 1));
         if_a1.address = 1'($urandom_range(0, 1));
         #1;
         chk("boot_m0_waitrequest", 32'(if_a0.waitrequest), 32'd1);
         chk("boot_m1_waitrequest", 32'(if_a1.waitrequest), 32'd1);
         chk("boot_check_done", 32'(done_a), 32'd0);
         if (k == 4) chk("chk_id_s_address", 32'(s_addr_a), 32'd0);
         if (k == 5) chk("chk_ts_s_address", 32'(s_addr_a), 32'd1);
         @(negedge clock);
      end
      if_a0.read = 1'b0;
      if_a1.read = 1'b0;
      #1;
      chk("a_check_done", 32'(done_a), 32'd1);
      chk("a_check_pass", 32'(pass_a), 32'(exp_pass_a));
      chk("b_check_done", 32'(done_b), 32'd1);
      chk("b_check_pass", 32'(pass_b), 32'(exp_pass_b));
      chk("boot_m0_readdatavalid", 32'(if_a0.readdatavalid), 32'd0);
      fault_m = !exp_pass_a;
      saddr_m = 1'b1;
   endtask

   initial begin
      clock    = 1'b0;
      reset    = 1'b1;
      checks   = 0;
      failures = 0;
      id_a = EXP_ID;
      ts_a = EXP_TS;
      id_b = EXP_ID;
      ts_b = 32'd0;
      if_a0.read = 1'b0; if_a0.address = 1'b0;
      if_a1.read = 1'b0; if_a1.address = 1'b0;
      if_b0.read = 1'b0; if_b0.address = 1'b0;
      if_b1.read = 1'b0; if_b1.address = 1'b0;

      boot(1'b1, 1'b1);

      // Contested: m0 reads timestamp, m1 reads ID, grants must alternate.
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      // Uncontested back-to-back on m1.
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'(k % 2));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 60; k++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Reset right after an m0 grant drops the pending response.
      if_a0.read    = 1'b1;
      if_a0.address = 1'b0;
      if_a1.read    = 1'b0;
      #1;
      chk("pre_reset_m0_waitrequest", 32'(if_a0.waitrequest), 32'd0);
      @(posedge clock);
      #1;
      reset      = 1'b1;
      if_a0.read = 1'b0;
      @(negedge clock);
      chk("midrst_m0_readdatavalid", 32'(if_a0.readdatavalid), 32'd0);
      chk("midrst_check_done", 32'(done_a), 32'd0);

      // Wrong ID with strict mode: check fails and all reads return the error word.
      id_a = 32'h2014_1114;
      boot(1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("fault_m0_readdata", if_a0.readdata, ERR_W);
      for (int k = 0; k < 20; k++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("fault_check_pass_hold", 32'(pass_a), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
